// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
// pc_sequencer
// Program-counter sequencer for the pipelined MIPS core. Owns the PC and
// picks the next PC from sequential, branch, jump and register targets. It
// vectors to the illegal-instruction and interrupt handlers and records the
// return address in EPC. Bit ADDR_W-1 of the PC is the kernel-mode bit.
// PC arithmetic never carries into the kernel bit. A user-mode jr cannot set
// the kernel bit.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   stall            hold pc/epc/exc_cause this cycle (irq still latched)
//   pc_src[2:0]      000 PC+4, 001 branch, 010 jump, 011 register, 1xx illegal
//   branch_taken     branch condition, used only for pc_src = 001
//   imm16, jtarget   branch word offset and jump target field
//   reg_target       jr/jalr register value
//   illop, irq       illegal-instruction flag, level interrupt request
//   pc, pc_plus4     current PC and its sequential successor
//   epc              exception return address
//   kernel           pc[ADDR_W-1]
//   exc_taken        one-cycle pulse in the first cycle a vector is in pc
//   exc_cause        00 none, 01 illop, 10 irq; held until the next exception
//
// Build option: define PC_SEQ_IRQ_SYNC_EN to route irq through a two-flop
// synchroniser before it reaches the pending flag. This adds 2 edges of
// interrupt latency.
module pc_sequencer #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        pc_src,
  input  logic              branch_taken,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jtarget,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              illop,
  input  logic              irq,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc,
  output logic              kernel,
  output logic              exc_taken,
  output logic [1:0]        exc_cause
);
  localparam int LW = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] RESET_PC = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ILLOP_PC = ILLOP_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] XADR_PC  = XADR_VEC[ADDR_W-1:0];

  // Adds on the low bits only, keeping the kernel bit of base unchanged.
  function automatic logic [ADDR_W-1:0] add_keep_kernel(
    input logic [ADDR_W-1:0] base,
    input logic [LW-1:0]     delta
  );
    logic [LW-1:0] low;
    low = base[LW-1:0] + delta;
    return {base[ADDR_W-1], low};
  endfunction

  logic              irq_pend;
  logic              irq_in;
  logic              take_ill;
  logic              take_irq;
  logic              pend_n;
  logic              exc_n;
  logic [1:0]        cause_n;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] epc_n;
  logic signed [LW-1:0] br_off;

`ifdef PC_SEQ_IRQ_SYNC_EN
  logic irq_meta_p0;
  logic irq_sync_p1;

  // irq synchroniser, runs regardless of stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_meta_p0 <= 1'b0;
      irq_sync_p1 <= 1'b0;
    end else begin
      irq_meta_p0 <= irq;
      irq_sync_p1 <= irq_meta_p0;
    end
  end

  assign irq_in = irq_sync_p1;
`else
  assign irq_in = irq;
`endif

  assign kernel   = pc[ADDR_W-1];
  assign pc_plus4 = add_keep_kernel(pc, LW'(4));
  assign br_off   = {{(LW - 18){imm16[15]}}, imm16, 2'b00};

  // Illegal instruction beats a pending interrupt, and the pending flag
  // survives so the interrupt fires once user code resumes.
  always_comb begin
    take_ill = illop | pc_src[2];
    take_irq = ~take_ill & irq_pend & ~kernel;
    pc_n     = pc;
    epc_n    = epc;
    cause_n  = exc_cause;
    exc_n    = 1'b0;
    pend_n   = irq_pend | irq_in;
    if (!stall) begin
      if (take_ill) begin
        pc_n    = ILLOP_PC;
        epc_n   = pc_plus4;
        cause_n = 2'b01;
        exc_n   = 1'b1;
      end else if (take_irq) begin
        // epc = pc so the interrupted instruction re-executes on return
        pc_n    = XADR_PC;
        epc_n   = pc;
        cause_n = 2'b10;
        exc_n   = 1'b1;
        pend_n  = 1'b0;
      end else begin
        unique case (pc_src[1:0])
          2'b01:   pc_n = branch_taken ? add_keep_kernel(pc_plus4, $unsigned(br_off))
                                       : pc_plus4;
          2'b10:   pc_n = {pc_plus4[ADDR_W-1:28], jtarget, 2'b00};
          2'b11:   pc_n = kernel ? reg_target : {1'b0, reg_target[LW-1:0]};
          default: pc_n = pc_plus4;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      epc       <= '0;
      exc_cause <= 2'b00;
      exc_taken <= 1'b0;
      irq_pend  <= 1'b0;
    end else begin
      pc        <= pc_n;
      epc       <= epc_n;
      exc_cause <= cause_n;
      exc_taken <= exc_n;
      irq_pend  <= pend_n;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
module tb_pc_sequencer;
  localparam logic [31:0] MSB  = 32'h8000_0000;
  localparam logic [31:0] LOW  = 32'h7FFF_FFFF;
  localparam logic [31:0] RVEC = 32'h8000_0000;
  localparam logic [31:0] IVEC = 32'h8000_0004;
  localparam logic [31:0] XVEC = 32'h8000_0008;
`ifdef PC_SEQ_IRQ_SYNC_EN
  localparam int IRQ_LAT = 4;
`else
  localparam int IRQ_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, illop, irq;
  logic [2:0]  pc_src;
  logic [15:0] imm16;
  logic [25:0] jtarget;
  logic [31:0] reg_target;
  logic [31:0] pc, pc_plus4, epc;
  logic        kernel, exc_taken;
  logic [1:0]  exc_cause;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  logic        m_exc, m_pend, m_s1, m_s2;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
    .branch_taken(branch_taken), .imm16(imm16), .jtarget(jtarget),
    .reg_target(reg_target), .illop(illop), .irq(irq), .pc(pc),
    .pc_plus4(pc_plus4), .epc(epc), .kernel(kernel),
    .exc_taken(exc_taken), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RVEC; m_epc = '0; m_cause = 2'b00; m_exc = 1'b0;
    m_pend = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  // One clock edge of the sequencer, from the rules in plain arithmetic.
  task automatic model_edge();
    logic [31:0] p4, off;
    logic        irq_in;
    p4  = (m_pc & MSB) | ((m_pc + 32'd4) & LOW);
    off = 32'(int'($signed(imm16)) * 4);
`ifdef PC_SEQ_IRQ_SYNC_EN
    irq_in = m_s2; m_s2 = m_s1; m_s1 = irq;
`else
    irq_in = irq;
`endif
    if (stall) begin
      m_exc = 1'b0; m_pend = m_pend | irq_in;
    end else if (illop || pc_src >= 3'd4) begin
      m_epc = p4; m_pc = IVEC; m_cause = 2'd1; m_exc = 1'b1; m_pend = m_pend | irq_in;
    end else if (m_pend && m_pc < MSB) begin
      m_epc = m_pc; m_pc = XVEC; m_cause = 2'd2; m_exc = 1'b1; m_pend = 1'b0;
    end else begin
      m_exc = 1'b0; m_pend = m_pend | irq_in;
      if (pc_src == 3'd1 && branch_taken) m_pc = (m_pc & MSB) | ((p4 + off) & LOW);
      else if (pc_src == 3'd2)            m_pc = (p4 & 32'hF000_0000) | (32'(jtarget) << 2);
      else if (pc_src == 3'd3)            m_pc = m_pc[31] ? reg_target : (reg_target & LOW);
      else                                m_pc = p4;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; pc_src = 3'd0; branch_taken = 0; imm16 = '0; jtarget = '0;
    reg_target = '0; illop = 0; irq = 0;
  endtask

  task automatic jr(input logic [31:0] t);
    pc_src = 3'd3; reg_target = t; step(); pc_src = 3'd0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pc, epc, kernel, exc_taken, exc_cause} !== {RVEC, 32'h0, 1'b1, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_state got pc=%h epc=%h k=%b exc=%b cause=%b want pc=%h epc=0 k=1 exc=0 cause=00",
               pc, epc, kernel, exc_taken, exc_cause, RVEC);
    end
    reset = 0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (pc !== RVEC + 32'(4 * i) || kernel !== 1'b1) begin
        errors++;
        $display("FAIL seq_%0d got pc=%h k=%b want pc=%h k=1", i, pc, kernel, RVEC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_register_jump();
    jr(32'h0040_0000);
    checks++;
    if (pc !== 32'h0040_0000 || kernel !== 1'b0) begin
      errors++; $display("FAIL jr_to_user got pc=%h k=%b want 00400000 k=0", pc, kernel);
    end
    jr(32'h8000_1234);
    checks++;
    if (pc !== 32'h0000_1234) begin
      errors++; $display("FAIL jr_msb_block got pc=%h want 00001234", pc);
    end
    checks++;
    if (pc_plus4 !== 32'h0000_1238) begin
      errors++; $display("FAIL pc_plus4 got %h want 00001238", pc_plus4);
    end
  endtask

  task automatic test_branch();
    jr(32'h0040_0000);
    pc_src = 3'd1; branch_taken = 1; imm16 = 16'hFFFF; step();
    checks++;
    if (pc !== 32'h0040_0000) begin
      errors++; $display("FAIL branch_back got pc=%h want 00400000", pc);
    end
    imm16 = 16'h0004; step();
    checks++;
    if (pc !== 32'h0040_0014) begin
      errors++; $display("FAIL branch_fwd got pc=%h want 00400014", pc);
    end
    jr(32'h0040_0000);
    pc_src = 3'd1; branch_taken = 0; step();
    checks++;
    if (pc !== 32'h0040_0004) begin
      errors++; $display("FAIL branch_not_taken got pc=%h want 00400004", pc);
    end
    idle_inputs();
    jr(32'h7FFF_FFFC);
    step();
    checks++;
    if (pc !== 32'h0000_0000) begin
      errors++; $display("FAIL user_wrap got pc=%h want 00000000", pc);
    end
  endtask

  task automatic test_irq();
    jr(32'h0040_0020);
    stall = 1; irq = 1; step(); irq = 0;
    checks++;
    if (pc !== 32'h0040_0020 || exc_taken !== 1'b0) begin
      errors++; $display("FAIL irq_stalled got pc=%h exc=%b want 00400020 exc=0", pc, exc_taken);
    end
    repeat (IRQ_LAT - 2) step();
    stall = 0; step();
    checks++;
    if ({pc, epc, exc_taken, exc_cause} !== {XVEC, 32'h0040_0020, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL irq_vector got pc=%h epc=%h exc=%b cause=%b want 80000008 00400020 1 10",
               pc, epc, exc_taken, exc_cause);
    end
    step();
    checks++;
    if ({pc, exc_taken, exc_cause} !== {32'h8000_000C, 1'b0, 2'b10}) begin
      errors++;
      $display("FAIL irq_pulse_end got pc=%h exc=%b cause=%b want 8000000C 0 10", pc, exc_taken, exc_cause);
    end
    // kernel-mode request is deferred, not dropped
    irq = 1; step(); irq = 0;
    repeat (3) step();
    checks++;
    if (pc !== 32'h8000_001C || exc_taken !== 1'b0) begin
      errors++; $display("FAIL irq_kernel_defer got pc=%h exc=%b want 8000001C 0", pc, exc_taken);
    end
    jr(32'h0040_0020);
    checks++;
    if (pc !== 32'h0040_0020 || kernel !== 1'b0) begin
      errors++; $display("FAIL irq_return got pc=%h k=%b want 00400020 0", pc, kernel);
    end
    step();
    checks++;
    if ({pc, epc, exc_taken, exc_cause} !== {XVEC, 32'h0040_0020, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL irq_after_return got pc=%h epc=%h exc=%b cause=%b want 80000008 00400020 1 10",
               pc, epc, exc_taken, exc_cause);
    end
  endtask

  task automatic test_illop_irq();
    irq = 1; step(); irq = 0;
    repeat (IRQ_LAT - 1) step();
    jr(32'h0040_0040);
    illop = 1; step(); illop = 0;
    checks++;
    if ({pc, epc, exc_taken, exc_cause} !== {IVEC, 32'h0040_0044, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL illop_over_irq got pc=%h epc=%h exc=%b cause=%b want 80000004 00400044 1 01",
               pc, epc, exc_taken, exc_cause);
    end
    jr(32'h0040_0044);
    step();
    checks++;
    if ({pc, epc, exc_cause} !== {XVEC, 32'h0040_0044, 2'b10}) begin
      errors++;
      $display("FAIL irq_kept got pc=%h epc=%h cause=%b want 80000008 00400044 10", pc, epc, exc_cause);
    end
  endtask

  task automatic test_stall();
    jr(32'h0040_0100);
    stall = 1; pc_src = 3'd2; illop = 1; jtarget = 26'h123;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== 32'h0040_0100 || exc_taken !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d got pc=%h exc=%b want 00400100 0", i, pc, exc_taken);
      end
    end
    stall = 0; step();
    checks++;
    if ({pc, epc, exc_taken, exc_cause} !== {IVEC, 32'h0040_0104, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL stall_release got pc=%h epc=%h exc=%b cause=%b want 80000004 00400104 1 01",
               pc, epc, exc_taken, exc_cause);
    end
    stall = 1; illop = 0; step();
    #2 reset = 1;
    #1;
    checks++;
    if ({pc, epc, exc_taken, exc_cause} !== {RVEC, 32'h0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL async_reset got pc=%h epc=%h exc=%b cause=%b want 80000000 0 0 00",
               pc, epc, exc_taken, exc_cause);
    end
    model_reset();
    #1 reset = 0;
    idle_inputs();
    step();
    checks++;
    if (pc !== 32'h8000_0004) begin
      errors++; $display("FAIL after_reset got pc=%h want 80000004", pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_p4;
    for (int i = 0; i < 400; i++) begin
      stall        = ($urandom_range(7) == 0);
      illop        = ($urandom_range(15) == 0);
      irq          = ($urandom_range(11) == 0);
      pc_src       = ($urandom_range(19) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3));
      branch_taken = 1'($urandom);
      imm16        = 16'($urandom);
      jtarget      = 26'($urandom);
      reg_target   = $urandom;
      step();
      exp_p4 = (m_pc & MSB) | ((m_pc + 32'd4) & LOW);
      checks++;
      if ({pc, pc_plus4, epc, kernel, exc_taken, exc_cause} !==
          {m_pc, exp_p4, m_epc, m_pc[31], m_exc, m_cause}) begin
        errors++;
        $display("FAIL random_%0d got pc=%h p4=%h epc=%h k=%b exc=%b cause=%b want pc=%h p4=%h epc=%h k=%b exc=%b cause=%b",
                 i, pc, pc_plus4, epc, kernel, exc_taken, exc_cause,
                 m_pc, exp_p4, m_epc, m_pc[31], m_exc, m_cause);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_register_jump();
    test_branch();
    test_irq();
    test_illop_irq();
    test_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
